// File: rtl/fir_decim_buffer.sv
// -----------------------------------------------------------------------------
// fir_decim_buffer
//   Sits after the 8-bit FIR filter. It block-averages groups of
//   2^DECIM_LOG2 valid input samples (decimation by averaging), queues each
//   average in a 2^DEPTH_LOG2-entry FIFO, and presents the FIFO head on a
//   valid/ready interface. A sticky flag records any average that was dropped
//   because the FIFO was full.
//
//   Optional build macro: FIR_DECIM_ROUND_EN
//     defined   -> average rounds half up and saturates to 2^DW-1
//     undefined -> average is truncated
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active low
//   in_valid   in   in_data carries a filter sample this cycle
//   in_data    in   [DW-1:0] filter sample, unsigned
//   out_valid  out  FIFO non-empty, out_data valid
//   out_ready  in   consumer takes out_data this cycle
//   out_data   out  [DW-1:0] FIFO head sample
//   count      out  [DEPTH_LOG2:0] FIFO occupancy, 0..2^DEPTH_LOG2
//   overflow   out  sticky: a decimated sample was dropped
//   clr_ovf    in   synchronous clear of overflow (a same-edge drop wins)
// -----------------------------------------------------------------------------
module fir_decim_buffer #(
  parameter int DW         = 8,
  parameter int DECIM_LOG2 = 2,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  input  logic                clr_ovf
);

  // Accumulator is wide enough for a whole group, so it can never wrap.
  localparam int AW    = DW + DECIM_LOG2;
  localparam int SW    = AW + 1;
  localparam int PW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0]       PHASE_LAST = PW'((1 << DECIM_LOG2) - 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
`ifdef FIR_DECIM_ROUND_EN
  // Half an LSB of the averaged result; zero for pass-through.
  localparam logic [SW-1:0] ROUND_ADD = SW'((1 << DECIM_LOG2) >> 1);
  localparam logic [SW-1:0] SAT_MAX   = SW'((1 << DW) - 1);
`endif

  logic [AW-1:0]         acc_r;
  logic [AW-1:0]         acc_nxt_s;
  logic [PW-1:0]         phase_r;
  logic [PW-1:0]         phase_nxt_s;
  logic [SW-1:0]         sum_s;
  logic [DW-1:0]         result_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  drop_s;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  valid_r;
  logic                  ovf_r;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DW-1:0]         mem_r [DEPTH];
`ifdef FIR_DECIM_ROUND_EN
  logic [SW-1:0]         quot_s;
`endif

  // Group accumulation, phase tracking and the averaged result of a group.
  always_comb begin
    acc_nxt_s   = acc_r;
    phase_nxt_s = phase_r;
    push_s      = 1'b0;
    sum_s       = SW'(acc_r) + SW'(in_data);
`ifdef FIR_DECIM_ROUND_EN
    quot_s = (sum_s + ROUND_ADD) >> DECIM_LOG2;
    if (quot_s > SAT_MAX) begin
      result_s = '1;
    end else begin
      result_s = DW'(quot_s);
    end
`else
    result_s = DW'(sum_s >> DECIM_LOG2);
`endif
    if (in_valid) begin
      if (phase_r == PHASE_LAST) begin
        // Group complete: push, then restart even if the push gets dropped.
        push_s      = 1'b1;
        acc_nxt_s   = '0;
        phase_nxt_s = '0;
      end else begin
        acc_nxt_s   = acc_r + AW'(in_data);
        phase_nxt_s = phase_r + PW'(1);
      end
    end else begin
      acc_nxt_s   = acc_r;
      phase_nxt_s = phase_r;
    end
  end

  // FIFO push/pop arbitration and next occupancy.
  always_comb begin
    pop_s       = valid_r & out_ready;
    full_s      = (count_r == DEPTH_CNT);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    wr_en_s     = push_s & (~full_s | pop_s);
    drop_s      = push_s & full_s & ~pop_s;
    count_nxt_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_nxt_s = count_r - (DEPTH_LOG2 + 1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state: accumulator, phase, pointers, occupancy and flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_r    <= '0;
      phase_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      acc_r   <= acc_nxt_s;
      phase_r <= phase_nxt_s;
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != '0);
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // FIFO storage; cleared on reset so the head reads 0 when empty.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= result_s;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// -----------------------------------------------------------------------------
// tb_fir_decim_buffer
//   Self-checking bench for fir_decim_buffer with default parameters
//   (DW=8, factor 4, depth 8). Table-driven vectors, hand-written corner
//   sequences, and randomized traffic checked against a queue-based model.
// -----------------------------------------------------------------------------
module tb_fir_decim_buffer;

  localparam int F     = 4;
  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       overflow;

  fir_decim_buffer dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: pending group samples, FIFO contents, flag.
  int mq[$];
  int grp[$];
  int m_ovf = 0;

  typedef struct {
    int v; int d; int r; int c;
    int ev; int ed; int ecnt; int eovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int avg_of(input int sum);
    int r;
`ifdef FIR_DECIM_ROUND_EN
    r = (sum + F / 2) / F;
    if (r > 255) r = 255;
`else
    r = sum / F;
`endif
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    grp.delete();
    m_ovf = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and step past the edge.
  task automatic apply(input int v, input int d, input int r, input int c);
    int n0, s, res;
    bit pop, push, drop;
    in_valid  = (v != 0);
    in_data   = d[7:0];
    out_ready = (r != 0);
    clr_ovf   = (c != 0);
    n0   = mq.size();
    pop  = (n0 != 0) && (r != 0);
    push = 1'b0;
    res  = 0;
    if (v != 0) begin
      grp.push_back(d & 255);
      if (grp.size() == F) begin
        s = 0;
        foreach (grp[i]) s += grp[i];
        res  = avg_of(s);
        push = 1'b1;
        grp.delete();
      end
    end
    if (pop) void'(mq.pop_front());
    drop = push && (n0 == DEPTH) && !pop;
    if (push && !drop) mq.push_back(res);
    if (drop) m_ovf = 1;
    else if (c != 0) m_ovf = 0;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, int'(out_valid), int'(mq.size() != 0));
    chk({tag, "_count"}, int'(count), mq.size());
    chk({tag, "_ovf"}, int'(overflow), m_ovf);
    if (mq.size() != 0) chk({tag, "_data"}, int'(out_data), mq[0]);
  endtask

  // Asynchronous reset pulse, checked before any clock edge follows.
  task automatic pulse_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    RST = 1'b0;
    #2;
    chk({tag, "_rst_valid"}, int'(out_valid), 0);
    chk({tag, "_rst_count"}, int'(count), 0);
    chk({tag, "_rst_ovf"}, int'(overflow), 0);
    chk({tag, "_rst_data"}, int'(out_data), 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  vec_t tab[15];
  int   avg_basic;

  initial begin
`ifdef FIR_DECIM_ROUND_EN
    avg_basic = 26;
`else
    avg_basic = 25;
`endif
    // basic average, then full-scale 255 and zero groups
    tab[0]  = '{1, 10, 1, 0, 0, 0, 0, 0};
    tab[1]  = '{1, 20, 1, 0, 0, 0, 0, 0};
    tab[2]  = '{1, 30, 1, 0, 0, 0, 0, 0};
    tab[3]  = '{1, 42, 1, 0, 1, avg_basic, 1, 0};
    tab[4]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    tab[5]  = '{1, 255, 0, 0, 0, 0, 0, 0};
    tab[6]  = '{1, 255, 0, 0, 0, 0, 0, 0};
    tab[7]  = '{1, 255, 0, 0, 0, 0, 0, 0};
    tab[8]  = '{1, 255, 0, 0, 1, 255, 1, 0};
    tab[9]  = '{1, 0, 0, 0, 1, 255, 1, 0};
    tab[10] = '{1, 0, 0, 0, 1, 255, 1, 0};
    tab[11] = '{1, 0, 0, 0, 1, 255, 1, 0};
    tab[12] = '{1, 0, 0, 0, 1, 255, 2, 0};
    tab[13] = '{0, 0, 1, 0, 1, 0, 1, 0};
    tab[14] = '{0, 0, 1, 0, 0, 0, 0, 0};

    // Power-on reset
    #12;
    chk("por_valid", int'(out_valid), 0);
    chk("por_count", int'(count), 0);
    chk("por_ovf", int'(overflow), 0);
    chk("por_data", int'(out_data), 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;

    // Reset mid-operation with three entries queued
    for (int g = 5; g <= 7; g++)
      for (int k = 0; k < F; k++) apply(1, g, 0, 0);
    chk("pre_rst_count", int'(count), 3);
    pulse_reset("mid");

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      apply(tab[i].v, tab[i].d, tab[i].r, tab[i].c);
      chk($sformatf("tab%0d_valid", i), int'(out_valid), tab[i].ev);
      chk($sformatf("tab%0d_count", i), int'(count), tab[i].ecnt);
      chk($sformatf("tab%0d_ovf", i), int'(overflow), tab[i].eovf);
      if (tab[i].ev != 0) chk($sformatf("tab%0d_data", i), int'(out_data), tab[i].ed);
    end

    // Gapped group: 4,_,_,8,12,_,16 averages to 10
    apply(1, 4, 1, 0);
    apply(0, 0, 1, 0);
    apply(0, 0, 1, 0);
    apply(1, 8, 1, 0);
    apply(1, 12, 1, 0);
    apply(0, 0, 1, 0);
    chk("gap_pending", int'(out_valid), 0);
    apply(1, 16, 1, 0);
    chk("gap_valid", int'(out_valid), 1);
    chk("gap_data", int'(out_data), 10);
    apply(0, 0, 1, 0);
    chk("gap_drained", int'(count), 0);

    // Reset discards a partial group
    apply(1, 7, 0, 0);
    apply(1, 9, 0, 0);
    pulse_reset("grp");
    for (int k = 0; k < F; k++) apply(1, 100, 0, 0);
    chk("fresh_count", int'(count), 1);
    chk("fresh_data", int'(out_data), 100);
    apply(0, 0, 1, 0);

    // Overflow: nine groups into an eight-entry FIFO with no reads
    for (int g = 1; g <= 9; g++)
      for (int k = 0; k < F; k++) apply(1, g, 0, 0);
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag", int'(overflow), 1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ovf_drain%0d", k), int'(out_data), k);
      apply(0, 0, 1, 0);
      check_model("ovf_drain");
    end
    chk("ovf_empty", int'(out_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);
    apply(0, 0, 0, 1);
    chk("ovf_cleared", int'(overflow), 0);

    // Full with a pop on the edge the ninth group lands
    for (int g = 1; g <= 8; g++)
      for (int k = 0; k < F; k++) apply(1, g, 0, 0);
    for (int k = 0; k < F - 1; k++) apply(1, 9, 0, 0);
    chk("fp_full", int'(count), 8);
    apply(1, 9, 1, 0);
    chk("fp_count", int'(count), 8);
    chk("fp_ovf", int'(overflow), 0);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("fp_drain%0d", k), int'(out_data), k);
      apply(0, 0, 1, 0);
    end
    chk("fp_empty", int'(count), 0);

    // Randomized traffic against the model (fill-heavy, then drain-heavy)
    for (int n = 0; n < 600; n++) begin
      int v, d, r, c;
      v = ($urandom % 4 != 0) ? 1 : 0;
      d = int'($urandom % 256);
      if (n < 300) r = ($urandom % 4 == 0) ? 1 : 0;
      else         r = ($urandom % 4 != 0) ? 1 : 0;
      c = ($urandom % 20 == 0) ? 1 : 0;
      apply(v, d, r, c);
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_decim_buffer.md
Name: fir_decim_buffer

Overview:
- Downstream stage of the 8-bit FIR filter. Consumes the filter output sample stream and block-averages it by 2^DECIM_LOG2, i.e. decimates by averaging.
- Stores decimated samples in a small FIFO.
- Presents them on a valid/ready interface to the next consumer, e.g. a serializer or bus bridge.
- Provides rate decoupling and a sticky overflow flag.

Parameters:
- DW, 8, sample width; matches the filter output width.
- DECIM_LOG2, 2, log2 of the decimation factor (factor 4); 0 = pass-through.
- DEPTH_LOG2, 3, log2 of FIFO depth (8 entries).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a filter output sample this cycle.
- in_data  input  DW  filter output sample, unsigned.
- out_valid  output  1  FIFO non-empty; out_data valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  DW  FIFO head sample.
- count  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- overflow  output  1  sticky: a decimated sample was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (RST low, async): accumulator=0, phase=0, read/write pointers=0, count=0, overflow=0, out_valid=0. out_data reads 0 after reset; FIFO memory needs no reset beyond entry 0.
- Accumulator width is DW+DECIM_LOG2, so no wrap is possible. Phase counter runs 0..2^DECIM_LOG2-1.
- in_valid=1 and phase < last:
  - acc <= acc + in_data.
  - phase <= phase+1.
- in_valid=1 and phase == last:
  - result = (acc + in_data) >> DECIM_LOG2, truncated to DW bits.
  - push result to the FIFO on the same edge.
  - acc <= 0, phase <= 0.
- in_valid=0: acc and phase hold. Gaps are allowed anywhere in a group.
- DECIM_LOG2=0: every valid sample is pushed unchanged.
- Latency: the push occurs on the edge that accepts the group's last sample. out_valid is high in the following cycle if the FIFO was empty. There is no bypass path.
- Pop: on an edge where out_valid & out_ready, the read pointer advances.
- out_data = mem[rd_ptr]. It must stay stable while out_valid & !out_ready.
- out_valid = (count != 0). count is registered and updates on the edge with net push/pop.
- Pointers wrap modulo 2^DEPTH_LOG2.
- Full (count == depth) and push without simultaneous pop:
  - sample is dropped.
  - FIFO contents, pointers and count unchanged.
  - overflow <= 1.
  - phase/acc still restart, so group alignment is preserved.
- Full and push with simultaneous pop: both happen, count stays at depth, no overflow.
- Empty and push: out_ready is ignored because out_valid=0. The push lands and count becomes 1.
- Simultaneous push and pop at any other occupancy: count unchanged.
- clr_ovf=1 clears overflow on the next edge. If a drop occurs on the same edge, set wins.
- Reset mid-group discards the partial accumulation. The next 2^DECIM_LOG2 valid samples form a fresh group.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined: result = (acc + in_data + 2^(DECIM_LOG2-1)) >> DECIM_LOG2, i.e. round half up. The sum width is extended by 1 bit internally. The result is saturated to 2^DW-1 if the rounded value exceeds the range. No effect when DECIM_LOG2=0.
- Undefined: plain truncation as specified in Behaviour.

Test Plan:
1. Reset check: assert RST low mid-operation with count=3 -> out_valid=0, count=0, overflow=0 immediately; after release, behaviour is identical to a fresh start.
2. Basic average: out_ready=1; in_data 10,20,30,42 on consecutive valid cycles -> one push, out_valid high the next cycle with out_data=25 (26 with FIR_DECIM_ROUND_EN); count returns to 0 after the pop.
3. Full-scale: 255 x4 -> out_data=255 in both builds, showing no accumulator wrap and correct saturation after rounding; 0 x4 -> 0.
4. Gapped input and reset mid-group:
   - in_valid pattern 1,0,0,1,1,0,1 with data 4,8,12,16 -> out_data=10.
   - separately: feed 2 samples, pulse RST, then feed 100 x4 -> out_data=100.
5. Overflow: out_ready=0; 36 valid samples of group values 1..9 -> count=8, overflow=1 after the 9th group. Drain yields 1..8 in order, and 9 is absent. clr_ovf pulse -> overflow=0.
6. Full with simultaneous pop: FIFO full; out_ready=1 on the exact edge the 9th group completes -> overflow stays 0, count stays 8, and the drained order is 2..9.
